// File: rtl/game_judge.sv
// game_judge
//   Referee sitting in front of the game FSM. Synchronizes the start button,
//   scores mole hits, takes lives on misses and turns the outcome into a
//   one-hot command for the FSM. Judging only happens while the FSM reports
//   inGame, and only once per game.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   start_btn   raw start button (asynchronous, active high)
//   hit_valid   one-cycle strobe qualifying hit_result
//   hit_result  10 = Success, 01 = hitLost, 11 = noneSense (ignored)
//   miss_tick   one-cycle strobe: a mole expired unhit
//   state       FSM state, one-hot: 0001 beforeGame, 0010 inGame,
//               0100 GameLost, 1000 GameWin
//   gameSig     one-hot command: 0001 keepCurrent, 0010 game_win,
//               0100 start_press, 1000 game_lost
//   score       hits this level
//   lives       remaining lives
//   level       current level
module game_judge #(
    parameter int WIN_SCORE = 20,
    parameter int MAX_LIVES = 3,
    parameter int MAX_LEVEL = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       hit_valid,
    input  logic [1:0] hit_result,
    input  logic       miss_tick,
    input  logic [3:0] state,
    output logic [3:0] gameSig,
    output logic [7:0] score,
    output logic [2:0] lives,
    output logic [1:0] level
);

    localparam logic [3:0] ST_BEFORE = 4'b0001;
    localparam logic [3:0] ST_INGAME = 4'b0010;
    localparam logic [3:0] ST_WIN    = 4'b1000;

    localparam logic [3:0] SIG_KEEP  = 4'b0001;
    localparam logic [3:0] SIG_WIN   = 4'b0010;
    localparam logic [3:0] SIG_START = 4'b0100;
    localparam logic [3:0] SIG_LOST  = 4'b1000;

    localparam logic [1:0] RES_SUCCESS = 2'b10;
    localparam logic [1:0] RES_LOST    = 2'b01;

    localparam logic [7:0] WIN_S      = 8'(WIN_SCORE);
    localparam logic [2:0] LIVES_INIT = 3'(MAX_LIVES);
    localparam logic [1:0] LEVEL_TOP  = 2'(MAX_LEVEL);

    function automatic logic [7:0] score_inc(input logic [7:0] s);
        return (s < WIN_S) ? s + 8'd1 : WIN_S;
    endfunction

    function automatic logic [2:0] lives_dec(input logic [2:0] l);
        return (l != 3'd0) ? l - 3'd1 : 3'd0;
    endfunction

    function automatic logic [1:0] level_inc(input logic [1:0] v);
        return (v < LEVEL_TOP) ? v + 2'd1 : LEVEL_TOP;
    endfunction

    logic       sync_p0, sync_p1, edge_p2;
    logic       ended;

    logic       rise, judging, succ, miss, win, loss;
    logic [7:0] score_n;
    logic [2:0] lives_n;
    logic [1:0] level_n;
    logic [3:0] sig_n;
    logic       ended_n;

    always_comb begin
        rise    = sync_p1 & ~edge_p2;
        judging = (state == ST_INGAME) && !ended;
        succ    = judging && hit_valid && (hit_result == RES_SUCCESS);
        miss    = judging && ((hit_valid && (hit_result == RES_LOST)) || miss_tick);

        score_n = succ ? score_inc(score) : score;
        lives_n = miss ? lives_dec(lives) : lives;
        level_n = level;

        // Outcome is decided on the updated counters so the pulse lands on
        // the same edge as the strobe that caused it.
        win  = judging && (score_n == WIN_S);
        loss = judging && !win && (lives_n == 3'd0);

        if (rise) begin
            if (state == ST_BEFORE) begin
                score_n = 8'd0;
                lives_n = LIVES_INIT;
                level_n = 2'd0;
            end else if (state == ST_WIN) begin
                score_n = 8'd0;
                level_n = level_inc(level);
            end
        end

        if (rise)      sig_n = SIG_START;
        else if (win)  sig_n = SIG_WIN;
        else if (loss) sig_n = SIG_LOST;
        else           sig_n = SIG_KEEP;

        // ended latches the outcome so one game yields one win/lost pulse;
        // it rearms as soon as the FSM leaves inGame.
        if (state != ST_INGAME) ended_n = 1'b0;
        else if (win || loss)   ended_n = 1'b1;
        else                    ended_n = ended;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            edge_p2 <= 1'b0;
            ended   <= 1'b0;
            gameSig <= SIG_KEEP;
            score   <= 8'd0;
            lives   <= LIVES_INIT;
            level   <= 2'd0;
        end else begin
            // stage p0/p1: two-flop synchronizer; p2: previous level for edge detect
            sync_p0 <= start_btn;
            sync_p1 <= sync_p0;
            edge_p2 <= sync_p1;
            ended   <= ended_n;
            gameSig <= sig_n;
            score   <= score_n;
            lives   <= lives_n;
            level   <= level_n;
        end
    end

endmodule

// File: tb/tb_game_judge.sv
module tb_game_judge;

    localparam int WIN  = 20;
    localparam int ML   = 3;
    localparam int MAXL = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_btn;
    logic       hit_valid;
    logic [1:0] hit_result;
    logic       miss_tick;
    logic [3:0] state;
    logic [3:0] gameSig;
    logic [7:0] score;
    logic [2:0] lives;
    logic [1:0] level;

    game_judge #(.WIN_SCORE(WIN), .MAX_LIVES(ML), .MAX_LEVEL(MAXL)) dut (
        .clk(clk), .rst(rst_n), .start_btn(start_btn), .hit_valid(hit_valid),
        .hit_result(hit_result), .miss_tick(miss_tick), .state(state),
        .gameSig(gameSig), .score(score), .lives(lives), .level(level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: game counters as plain integers
    int m_score, m_lives, m_level, m_sig;
    bit m_ended;
    bit past_btn[3];   // button level seen 1, 2 and 3 edges ago
    int n_start, n_win, n_lost, step_no;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_lives = ML; m_level = 0; m_sig = 1; m_ended = 0;
        past_btn[0] = 0; past_btn[1] = 0; past_btn[2] = 0;
    endtask

    task automatic model_edge();
        bit judging, succ, miss, pressed, win, loss;
        int ns, nl, nv;
        judging = (state == 4'b0010) && !m_ended;
        succ    = judging && hit_valid && (hit_result == 2'b10);
        miss    = judging && ((hit_valid && hit_result == 2'b01) || miss_tick);
        // button high two edges ago but low three edges ago
        pressed = past_btn[1] && !past_btn[2];
        ns = m_score; nl = m_lives; nv = m_level;
        if (succ) ns = (m_score + 1 > WIN) ? WIN : m_score + 1;
        if (miss) nl = (m_lives > 0) ? m_lives - 1 : 0;
        win  = judging && (ns == WIN);
        loss = judging && !win && (nl == 0);
        if (pressed && state == 4'b0001) begin ns = 0; nl = ML; nv = 0; end
        if (pressed && state == 4'b1000) begin ns = 0; nv = (nv + 1 > MAXL) ? MAXL : nv + 1; end
        m_sig = pressed ? 4 : win ? 2 : loss ? 8 : 1;
        if (state != 4'b0010) m_ended = 0;
        else if (win || loss) m_ended = 1;
        m_score = ns; m_lives = nl; m_level = nv;
        past_btn[2] = past_btn[1]; past_btn[1] = past_btn[0]; past_btn[0] = start_btn;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".gameSig"}, int'(gameSig), m_sig);
        check({tag, ".score"},   int'(score),   m_score);
        check({tag, ".lives"},   int'(lives),   m_lives);
        check({tag, ".level"},   int'(level),   m_level);
    endtask

    // one clock: inputs already driven; compare #1 after the edge, return at negedge
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        step_no++;
        compare_all(tag);
        if (gameSig == 4'b0100) n_start++;
        if (gameSig == 4'b0010) n_win++;
        if (gameSig == 4'b1000) n_lost++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hit_valid = 0; hit_result = 2'b00; miss_tick = 0;
    endtask

    task automatic press(input logic [3:0] st);
        state = st; idle_inputs();
        start_btn = 1;
        repeat (4) step("press");
        start_btn = 0;
        repeat (3) step("press");
    endtask

    task automatic strobe(input bit hv, input logic [1:0] hr, input bit mt);
        hit_valid = hv; hit_result = hr; miss_tick = mt;
        step("strobe");
        idle_inputs();
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic async_reset(input string tag);
        #2 rst_n = 0;
        #1;
        model_reset();
        compare_all(tag);
        #1 rst_n = 1;
    endtask

    int first_pulse;

    initial begin
        rst_n = 0; start_btn = 0; state = 4'b0001; idle_inputs();
        model_reset();
        step_no = 0; n_start = 0; n_win = 0; n_lost = 0;
        #12;
        compare_all("reset");
        check("reset.gameSig_const", int'(gameSig), 1);
        check("reset.lives_const", int'(lives), ML);
        @(negedge clk);
        rst_n = 1;

        // 1: held button, one start pulse on the 3rd edge
        step_no = 0; first_pulse = -1;
        start_btn = 1;
        for (int i = 0; i < 10; i++) begin
            step("t1");
            if (gameSig == 4'b0100 && first_pulse < 0) first_pulse = step_no;
        end
        start_btn = 0;
        step("t1");
        check("t1.pulse_count", n_start, 1);
        check("t1.pulse_edge", first_pulse, 3);
        check("t1.lives", int'(lives), 3);

        // 2: 20 successes win, 21st ignored
        state = 4'b0010; n_win = 0;
        for (int i = 0; i < 20; i++) begin
            strobe(1, 2'b10, 0);
            check("t2.score_count", int'(score), i + 1);
        end
        check("t2.win_sig", int'(gameSig), 2);
        strobe(1, 2'b10, 0);
        check("t2.score_sat", int'(score), 20);
        check("t2.win_count", n_win, 1);

        // 5: level advance from GameWin, saturating at 3
        for (int i = 0; i < 4; i++) press(4'b1000);
        check("t5.level_sat", int'(level), 3);
        check("t5.score", int'(score), 0);
        check("t5.lives_kept", int'(lives), 3);

        // 3: three misses lose, further hitLost ignored
        press(4'b0001);
        check("t3.level_reset", int'(level), 0);
        state = 4'b0010; n_lost = 0;
        for (int i = 0; i < 3; i++) strobe(0, 2'b00, 1);
        check("t3.lives_zero", int'(lives), 0);
        strobe(1, 2'b01, 0);
        check("t3.lost_count", n_lost, 1);
        check("t3.lives_sat", int'(lives), 0);

        // 4: success and miss together, win priority
        press(4'b0001);
        state = 4'b0010;
        for (int i = 0; i < 19; i++) strobe(1, 2'b10, 0);
        for (int i = 0; i < 2; i++) strobe(0, 2'b00, 1);
        strobe(1, 2'b10, 1);
        check("t4.score", int'(score), 20);
        check("t4.lives", int'(lives), 0);
        check("t4.win_prio", int'(gameSig), 2);

        // 6: asynchronous reset mid-game
        press(4'b0001);
        state = 4'b0010;
        for (int i = 0; i < 7; i++) strobe(1, 2'b10, 0);
        check("t6.score7", int'(score), 7);
        async_reset("t6.async");
        check("t6.score_cleared", int'(score), 0);
        n_start = 0; n_win = 0; n_lost = 0;
        state = 4'b0001;
        repeat (6) step("t6.after");
        check("t6.no_pulse", n_start + n_win + n_lost, 0);

        // randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) < 7) state = 4'b0010;
            else state = 4'b0001 << $urandom_range(0, 3);
            hit_valid  = ($urandom_range(0, 9) < 4);
            hit_result = 2'($urandom_range(0, 3));
            miss_tick  = ($urandom_range(0, 99) < 12);
            if ($urandom_range(0, 9) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 299) == 0) async_reset("rand.async");
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
